hdb3_tx_ctrl: RTL and testbench

//  Sequencer for the HDB3 transmit encoder chain (V-insert -> B-insert -> polarity).

---
 rtl/hdb3_tx_ctrl.sv | 144 ++++++++++++++
 tb/tb_hdb3_tx_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdb3_tx_ctrl.sv
// hdb3_tx_ctrl: start/run/drain sequencer that feeds an HDB3 encoder chain and tags accepted bits through its latency.
// Optional V/B statistics counters are built only when HDB3_TX_STATS_EN is defined.
module hdb3_tx_ctrl #(
    parameter int unsigned PIPE_LAT  = 8,
    parameter bit          IDLE_ONES = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             s_valid,
    input  logic             s_data,
    output logic             s_ready,
    output logic [1:0]       enc_in,
    input  logic [1:0]       enc_code,
    output logic             line_valid,
    output logic             busy,
    output logic [1:0]       state,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] v_count,
    output logic [CNT_W-1:0] b_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;

    localparam logic [1:0] SYM_ZERO   = 2'b00;
    localparam logic [1:0] SYM_MARK   = 2'b01;
    localparam logic [1:0] FILL_SYM   = IDLE_ONES ? SYM_MARK : SYM_ZERO;
    localparam logic [4:0] DRAIN_LOAD = 5'(PIPE_LAT);

    state_e              state_q;
    logic                s_ready_q;
    logic                busy_q;
    logic [1:0]          enc_in_q;
    logic [4:0]          drain_q;
    logic [PIPE_LAT-1:0] tag_q;
    logic                tag_d;

    // s_ready_q is high exactly in RUN, so this is the source handshake.
    assign tag_d = s_ready_q & s_valid;

    // Outputs are loaded from the next state so they change together with state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            enc_in_q  <= SYM_ZERO;
            drain_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    enc_in_q <= SYM_ZERO;
                    if (start && !stop) begin
                        state_q   <= ST_RUN;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    enc_in_q <= tag_d ? {1'b0, s_data} : FILL_SYM;
                    if (stop) begin
                        state_q   <= ST_DRAIN;
                        s_ready_q <= 1'b0;
                        drain_q   <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    enc_in_q <= SYM_ZERO;
                    drain_q  <= drain_q - 5'd1;
                    if (drain_q == 5'd1) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    s_ready_q <= 1'b0;
                    busy_q    <= 1'b0;
                    enc_in_q  <= SYM_ZERO;
                    drain_q   <= '0;
                end
            endcase
        end
    end

    // Tag line mirrors the chain latency so line_valid lines up with enc_code.
    always_ff @(posedge clk) begin
        // NOTE: the tag line is cleared on reset so no stale bit can raise line_valid afterwards.
        if (!rst_n) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= tag_d;
            for (int i = 1; i < int'(PIPE_LAT); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign state      = state_q;
    assign s_ready    = s_ready_q;
    assign busy       = busy_q;
    assign enc_in     = enc_in_q;
    assign line_valid = tag_q[PIPE_LAT-1];

`ifdef HDB3_TX_STATS_EN
    localparam logic [1:0] SYM_V = 2'b11;
    localparam logic [1:0] SYM_B = 2'b10;

    logic [CNT_W-1:0] v_cnt_q;
    logic [CNT_W-1:0] b_cnt_q;
    logic             v_hit;
    logic             b_hit;

    assign v_hit = line_valid && (enc_code == SYM_V);
    assign b_hit = line_valid && (enc_code == SYM_B);

    // Clear takes priority over a coincident increment; counters hold at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n || stats_clr) begin
            v_cnt_q <= '0;
            b_cnt_q <= '0;
        end else begin
            if (v_hit && (v_cnt_q != '1)) v_cnt_q <= v_cnt_q + CNT_W'(1);
            if (b_hit && (b_cnt_q != '1)) b_cnt_q <= b_cnt_q + CNT_W'(1);
        end
    end

    assign v_count = v_cnt_q;
    assign b_count = b_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = ^{stats_clr, enc_code};
    assign v_count      = '0;
    assign b_count      = '0;
`endif

endmodule

// File: tb/tb_hdb3_tx_ctrl.sv
// Bench for hdb3_tx_ctrl: a behavioural HDB3 chain drives enc_code, and a cycle model is compared every cycle.
// Directed tests cover reset, latency, idle fill, drain, priority and (with HDB3_TX_STATS_EN) statistics.
module tb_hdb3_tx_ctrl;

    localparam int unsigned PIPE_LAT = 8;
    localparam int unsigned CNT_W    = 3;
    localparam int          CMAX     = (1 << CNT_W) - 1;
    localparam int          CH_LEN   = PIPE_LAT - 1;
`ifdef HDB3_TX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam logic [1:0] ZERO  = 2'b00;
    localparam logic [1:0] MARK  = 2'b01;
    localparam logic [1:0] SYM_V = 2'b11;
    localparam logic [1:0] SYM_B = 2'b10;
    localparam logic [1:0] M_IDLE  = 2'b00;
    localparam logic [1:0] M_RUN   = 2'b01;
    localparam logic [1:0] M_DRAIN = 2'b10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_data = 1'b0;
    logic             stats_clr = 1'b0;
    logic [1:0]       enc_code = 2'b00;
    logic             s_ready;
    logic [1:0]       enc_in;
    logic             line_valid;
    logic             busy;
    logic [1:0]       state;
    logic [CNT_W-1:0] v_count;
    logic [CNT_W-1:0] b_count;

    int checks = 0;
    int failures = 0;

    hdb3_tx_ctrl #(
        .PIPE_LAT (PIPE_LAT),
        .IDLE_ONES(1'b1),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .enc_in    (enc_in),
        .enc_code  (enc_code),
        .line_valid(line_valid),
        .busy      (busy),
        .state     (state),
        .stats_clr (stats_clr),
        .v_count   (v_count),
        .b_count   (b_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural HDB3 chain (environment) ----------------
    logic [1:0] line_d [CH_LEN];
    int         pulses = 0;

    initial begin
        logic [1:0] cap;
        logic       rst_seen;
        for (int i = 0; i < CH_LEN; i++) line_d[i] = ZERO;
        forever begin
            @(negedge clk);
            cap = enc_in;
            @(posedge clk);
            rst_seen = rst_n;
            #1;
            if (!rst_seen) begin
                for (int i = 0; i < CH_LEN; i++) line_d[i] = ZERO;
                pulses = 0;
            end else begin
                for (int i = CH_LEN - 1; i > 0; i--) line_d[i] = line_d[i-1];
                line_d[0] = cap;
                if (cap == MARK) pulses++;
                if (line_d[0] == ZERO && line_d[1] == ZERO && line_d[2] == ZERO && line_d[3] == ZERO) begin
                    if (pulses % 2 == 0) line_d[3] = SYM_B;
                    line_d[0] = SYM_V;
                    pulses = 0;
                end
            end
            enc_code = line_d[CH_LEN-1];
        end
    end

    // ---------------- reference model ----------------
    int         cyc = 0;
    bit         model_live = 1'b0;
    logic [1:0] m_mode = M_IDLE;
    int         drain_end = 0;
    int         due_q[$];
    logic [1:0] exp_enc = ZERO;
    logic       exp_lv = 1'b0;
    int         exp_v = 0;
    int         exp_b = 0;

    initial begin
        bit acc;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                model_live = 1'b1;
                m_mode     = M_IDLE;
                due_q.delete();
                exp_enc    = ZERO;
                exp_lv     = 1'b0;
                exp_v      = 0;
                exp_b      = 0;
            end else if (model_live) begin
                acc = (m_mode == M_RUN) && s_valid;
                if (acc) due_q.push_back(cyc + PIPE_LAT);
                if (STATS) begin
                    if (stats_clr) begin
                        exp_v = 0;
                        exp_b = 0;
                    end else begin
                        if (exp_lv && enc_code == SYM_V && exp_v < CMAX) exp_v++;
                        if (exp_lv && enc_code == SYM_B && exp_b < CMAX) exp_b++;
                    end
                end
                exp_enc = (m_mode == M_RUN) ? (acc ? {1'b0, s_data} : MARK) : ZERO;
                case (m_mode)
                    M_IDLE:  if (start && !stop) m_mode = M_RUN;
                    M_RUN:   if (stop) begin m_mode = M_DRAIN; drain_end = cyc + PIPE_LAT; end
                    default: if (cyc == drain_end) m_mode = M_IDLE;
                endcase
                exp_lv = 1'b0;
                while (due_q.size() > 0 && due_q[0] <= cyc + 1) begin
                    if (due_q[0] == cyc + 1) exp_lv = 1'b1;
                    void'(due_q.pop_front());
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (model_live) begin
                check("cyc_state",      32'(state),      32'(m_mode));
                check("cyc_s_ready",    32'(s_ready),    32'(m_mode == M_RUN));
                check("cyc_busy",       32'(busy),       32'(m_mode != M_IDLE));
                check("cyc_enc_in",     32'(enc_in),     32'(exp_enc));
                check("cyc_line_valid", 32'(line_valid), 32'(exp_lv));
                check("cyc_v_count",    32'(v_count),    exp_v);
                check("cyc_b_count",    32'(b_count),    exp_b);
            end
        end
    end

    // Raises stats_clr in the exact cycle the first armed V carries line_valid.
    bit clr_arm = 1'b0;
    bit clr_pending = 1'b0;
    bit clr_fired = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (clr_pending) begin
                check("clr_beats_v", 32'(v_count), 0);
                check("clr_zero_b",  32'(b_count), 0);
                clr_pending = 1'b0;
            end
            if (clr_arm && exp_lv && enc_code == SYM_V) begin
                stats_clr   = 1'b1;
                clr_arm     = 1'b0;
                clr_pending = 1'b1;
                clr_fired   = 1'b1;
            end else begin
                stats_clr = 1'b0;
            end
        end
    end

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40 && state !== M_IDLE; i++) @(negedge clk);
        check(name, 32'(state), 32'(M_IDLE));
    endtask

    task automatic send_stream();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            s_valid = 1'b1;
            s_data  = (i == 0);
            stop    = (i == 8);
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_data  = 1'b0;
        stop    = 1'b0;
        wait_idle("stream_idle");
    endtask

    initial begin
        int lat;
        int dc;
        int lv_at;
        logic lv_busy;
        logic [1:0] pat [4];
        pat = '{2'b11, 2'b10, 2'b00, 2'b11};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_state",   32'(state),      0);
        check("rst_s_ready", 32'(s_ready),    0);
        check("rst_enc_in",  32'(enc_in),     0);
        check("rst_lv",      32'(line_valid), 0);
        check("rst_busy",    32'(busy),       0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // start and stop together in IDLE: stop wins.
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check("prio_state", 32'(state), 0);
        check("prio_busy",  32'(busy),  0);

        // Enter RUN, idle fill, start ignored in RUN.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("run_state",   32'(state),   1);
        check("run_s_ready", 32'(s_ready), 1);
        @(negedge clk);
        check("idle_fill", 32'(enc_in), 2'b01);
        check("idle_fill_lv", 32'(line_valid), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_run", 32'(state), 1);
        @(negedge clk);

        // Latency of one accepted mark.
        s_valid = 1'b1;
        s_data  = 1'b1;
        lat = 0;
        for (int k = 1; k <= int'(PIPE_LAT) + 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                s_valid = 1'b0;
                s_data  = 1'b0;
                check("enc_in_mark", 32'(enc_in), 2'b01);
            end
            if (line_valid === 1'b1 && lat == 0) lat = k;
        end
        check("latency", lat, PIPE_LAT);

        // An accepted zero is distinct from the mark fill.
        s_valid = 1'b1;
        s_data  = 1'b0;
        @(negedge clk);
        s_valid = 1'b0;
        check("enc_in_zero", 32'(enc_in), 2'b00);

        // Mixed valid/data pattern, then stop with the last bit accepted.
        for (int i = 0; i < 4; i++) begin
            s_valid = pat[i][1];
            s_data  = pat[i][0];
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = 1'b1;
        stop    = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = 1'b0;
        stop    = 1'b0;
        check("stop_bit_enc", 32'(enc_in), 2'b01);
        dc = 0;
        lv_at = -1;
        lv_busy = 1'b0;
        for (int i = 0; i < 40 && state !== M_IDLE; i++) begin
            if (state === M_DRAIN) dc++;
            if (line_valid === 1'b1) begin
                lv_at   = i;
                lv_busy = busy;
            end
            start = (i == 2);
            stop  = (i == 3);
            @(negedge clk);
        end
        start = 1'b0;
        stop  = 1'b0;
        check("drain_len",     dc, PIPE_LAT);
        check("drain_lv_at",   lv_at, PIPE_LAT - 1);
        check("drain_lv_busy", 32'(lv_busy), 1);
        check("drain_state",   32'(state), 0);
        check("drain_busy",    32'(busy),  0);
        repeat (3) @(negedge clk);

        // Statistics: 1 then eight zeros gives 000V then B00V.
        send_stream();
        check("stream1_v", 32'(v_count), STATS ? 2 : 0);
        check("stream1_b", 32'(b_count), STATS ? 1 : 0);
        repeat (3) @(negedge clk);
        clr_arm = 1'b1;
        send_stream();
        check("clr_fired", 32'(clr_fired), 1);
        check("stream2_v", 32'(v_count), STATS ? 1 : 0);
        check("stream2_b", 32'(b_count), STATS ? 1 : 0);
        for (int s = 0; s < 4; s++) begin
            repeat (2) @(negedge clk);
            send_stream();
        end
        check("sat_v", 32'(v_count), STATS ? CMAX : 0);
        check("sat_b", 32'(b_count), STATS ? 5 : 0);

        // Reset mid-RUN with bits in flight.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = 1'b1;
            @(negedge clk);
        end
        s_valid = 1'b0;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("midrst_state",   32'(state),   0);
        check("midrst_s_ready", 32'(s_ready), 0);
        check("midrst_enc_in",  32'(enc_in),  0);
        check("midrst_v",       32'(v_count), 0);
        for (int k = 0; k < int'(PIPE_LAT); k++) begin
            check("midrst_no_lv", 32'(line_valid), 0);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
